// File: rtl/fbwrite_pkg.sv
// fbwrite_pkg: framebuffer geometry, buffer layout and the FIFO entry format shared by the
// pixel writer and the display-side reader.
package fbwrite_pkg;
    localparam int FB_W = 256;
    localparam int FB_H = 240;
    localparam int CROP = 8;
    localparam logic [31:0] BUF1_OFS = 32'h0004_0000;

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  row;
        logic [23:0] pix;
    } px_t;

    // Byte offset inside the double buffer: buffer select lands on bit 18 (BUF1_OFS).
    function automatic logic [18:0] fb_offset(input logic sel, input logic [7:0] row, input logic [7:0] x);
        return {sel, row, x, 2'b00};
    endfunction
endpackage

// File: rtl/fbwrite_if.sv
// fbwrite_if: PPU pixel stream, framebuffer memory port and status/control of the writer.
interface fbwrite_if #(parameter int ADDRW = 32);
    logic [8:0]       outx;
    logic [8:0]       outy;
    logic             pxvalid;
    logic [23:0]      pix;
    logic [ADDRW-1:0] fbaddr;
    logic [31:0]      fbdata;
    logic             fbreq;
    logic             fback;
    logic             framedone;
    logic             dispsel;
    logic             overflow;
    logic             clrovf;

    modport master (
        output outx, outy, pxvalid, pix, fback, clrovf,
        input  fbaddr, fbdata, fbreq, framedone, dispsel, overflow
    );

    modport slave (
        input  outx, outy, pxvalid, pix, fback, clrovf,
        output fbaddr, fbdata, fbreq, framedone, dispsel, overflow
    );
endinterface

// File: rtl/fbwrite_pxfifo.sv
// pxfifo: synchronous FIFO of pixel entries; the caller never pops when empty and only
// pushes into a full FIFO in a cycle that also pops.
module pxfifo #(
    parameter int DEPTH = 16,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk)
        if (push) r_mem[r_wp] <= din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wp <= r_wp + 1'b1;
            if (pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = r_mem[r_rp];
    assign full  = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;
endmodule

// File: rtl/fbwrite.sv
// fbwrite: writes the PPU pixel stream into a double-buffered framebuffer over a req/ack port.
// Define OVERSCAN_CROP_EN to drop the top and bottom 8 lines and store 224 rows.
module fbwrite
    import fbwrite_pkg::*;
#(
    parameter int               ADDRW  = 32,
    parameter logic [ADDRW-1:0] FBBASE = 32'h0010_0000,
    parameter int               DEPTH  = 16
) (
    input logic       clk,
    input logic       reset,
    fbwrite_if.slave  bus
);
    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic             w_ack;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_row;
    px_t              w_din;
    px_t              w_dout;
    state_t           r_state;
    state_t           w_state_nx;
    logic [ADDRW-1:0] r_fbaddr;
    logic [31:0]      r_fbdata;
    logic             r_last;
    logic             r_framedone;
    logic             r_dispsel;
    logic             r_wsel;
    logic             r_overflow;

`ifdef OVERSCAN_CROP_EN
    localparam logic [7:0] LAST_ROW = 8'(FB_H - 2*CROP - 1);
    assign w_acc = bus.pxvalid && bus.outx < 9'(FB_W) && bus.outy >= 9'(CROP) && bus.outy < 9'(FB_H - CROP);
    assign w_row = 8'(bus.outy - 9'(CROP));
`else
    localparam logic [7:0] LAST_ROW = 8'(FB_H - 1);
    assign w_acc = bus.pxvalid && bus.outx < 9'(FB_W) && bus.outy < 9'(FB_H);
    assign w_row = bus.outy[7:0];
`endif

    assign w_din  = '{x: bus.outx[7:0], row: w_row, pix: bus.pix};
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    assign w_push = w_acc && (!w_full || w_pop);

    pxfifo #(.DEPTH(DEPTH), .W($bits(px_t))) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_ack      = 1'b0;
        if (r_state == IDLE) begin
            w_pop      = !w_empty;
            w_state_nx = w_empty ? IDLE : REQ;
        end else if (bus.fback) begin
            w_ack      = 1'b1;
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fbaddr    <= '0;
            r_fbdata    <= '0;
            r_last      <= 1'b0;
            r_framedone <= 1'b0;
            r_dispsel   <= 1'b1;
            r_wsel      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_framedone <= w_ack && r_last;
            r_overflow  <= (w_acc && !w_push) ? 1'b1 : bus.clrovf ? 1'b0 : r_overflow;
            if (w_pop) begin
                r_fbaddr <= FBBASE + ADDRW'(fb_offset(r_wsel, w_dout.row, w_dout.x));
                r_fbdata <= {8'h00, w_dout.pix};
                r_last   <= w_dout.x == 8'hFF && w_dout.row == LAST_ROW;
            end
            // Swap only once the closing pixel is in memory, so the display never sees a partial frame.
            if (w_ack && r_last) begin
                r_dispsel <= r_wsel;
                r_wsel    <= ~r_wsel;
            end
        end
    end

    assign bus.fbaddr    = r_fbaddr;
    assign bus.fbdata    = r_fbdata;
    assign bus.fbreq     = r_state == REQ;
    assign bus.framedone = r_framedone;
    assign bus.dispsel   = r_dispsel;
    assign bus.overflow  = r_overflow;
endmodule
